// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared widths and lock-state encoding for the register-bank
//               arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    LOCKED_R0 = 2'd1,
    LOCKED_R1 = 2'd2
  } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/reg_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_arbiter_if
// Description : One requester's access channel: valid/ready request with
//               lock hint, plus the one-cycle response pulse and read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_arbiter_if #(
  parameter int DATA_W = reg_bank_pkg::DATA_W,
  parameter int ADDR_W = reg_bank_pkg::ADDR_W
);

  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  // Requester side
  modport master (
    output valid, we, addr, wdata, lock,
    input  ready, rsp_valid, rsp_rdata
  );

  // Arbiter side
  modport slave (
    input  valid, we, addr, wdata, lock,
    output ready, rsp_valid, rsp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant. The pointer names the requester
//               that wins a tie; it can advance past the winner or be loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] req,
  input  wire logic       upd_en,    // move pointer to the loser after a grant
  input  wire logic       load_en,   // force the pointer (overrides upd_en)
  input  wire logic       load_ptr,  // value forced into the pointer
  output logic      [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Single requester wins outright; a tie goes to the pointer
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Pointer next value: after granting r0 point at r1 and vice versa
  always_comb begin
    ptr_d = ptr_q;
    if (load_en) begin
      ptr_d = load_ptr;
    end else if (upd_en && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_arbiter
// Description : Shares a 1R/1W register bank between two requesters with
//               round-robin arbitration, an atomic lock with timeout, and a
//               registered one-cycle response.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter #(
  parameter int DATA_W       = reg_bank_pkg::DATA_W,
  parameter int ADDR_W       = reg_bank_pkg::ADDR_W,
  parameter int LOCK_TIMEOUT = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  reg_bank_arbiter_if.slave      r0,
  reg_bank_arbiter_if.slave      r1,
  output logic                   bank_we,
  output logic      [ADDR_W-1:0] bank_write_addr,
  output logic      [DATA_W-1:0] bank_write_data,
  output logic      [ADDR_W-1:0] bank_read_addr,
  input  wire logic [DATA_W-1:0] bank_read_data,
  output logic                   lock_timeout
);

  import reg_bank_pkg::*;

  localparam int              CNT_W     = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  lock_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lock_to_q, lock_to_d;
  logic [1:0]        rsp_v_q, rsp_v_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;

  logic [1:0]        arb_req;
  logic [1:0]        arb_gnt;
  logic [1:0]        gnt;
  logic              timeout;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign arb_req = {r1.valid, r0.valid} & {2{~rst}};
  assign timeout = (state_q != UNLOCKED) && (cnt_q == C_TO_LAST);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (arb_req),
    .upd_en   (state_q == UNLOCKED),
    .load_en  (timeout),
    .load_ptr (state_q == LOCKED_R0),
    .gnt      (arb_gnt)
  );

  // Grant: arbiter decides when unlocked, otherwise only the lock owner
  always_comb begin
    gnt = 2'b00;
    case (state_q)
      UNLOCKED:  gnt = arb_gnt;
      LOCKED_R0: gnt = {1'b0, r0.valid};
      LOCKED_R1: gnt = {r1.valid, 1'b0};
      default:   gnt = 2'b00;
    endcase
    if (rst) begin
      gnt = 2'b00;
    end
  end

  assign r0.ready = gnt[0];
  assign r1.ready = gnt[1];

  // Bank drive from the granted request; read address holds when not reading
  always_comb begin
    sel_we          = gnt[1] ? r1.we    : r0.we;
    sel_addr        = gnt[1] ? r1.addr  : r0.addr;
    sel_wdata       = gnt[1] ? r1.wdata : r0.wdata;
    bank_we         = (gnt != 2'b00) && sel_we;
    bank_write_addr = bank_we ? sel_addr  : '0;
    bank_write_data = bank_we ? sel_wdata : '0;
    bank_read_addr  = ((gnt != 2'b00) && !sel_we) ? sel_addr : raddr_q;
  end

  // Lock FSM, timeout counter and response next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      UNLOCKED: begin
        cnt_d = '0;
        if (gnt[0] && r0.lock) begin
          state_d = LOCKED_R0;
        end else if (gnt[1] && r1.lock) begin
          state_d = LOCKED_R1;
        end
      end
      LOCKED_R0: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout || (gnt[0] && !r0.lock)) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      end
      LOCKED_R1: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout || (gnt[1] && !r1.lock)) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    endcase
    // Pulse is precomputed so it is high exactly in the forced-release cycle
    lock_to_d    = (state_d != UNLOCKED) && (cnt_d == C_TO_LAST);
    rsp_v_d      = gnt;
    rsp0_rdata_d = (gnt[0] && !r0.we) ? bank_read_data : '0;
    rsp1_rdata_d = (gnt[1] && !r1.we) ? bank_read_data : '0;
    raddr_d      = bank_read_addr;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      cnt_q        <= '0;
      lock_to_q    <= 1'b0;
      rsp_v_q      <= 2'b00;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
      raddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_to_q    <= lock_to_d;
      rsp_v_q      <= rsp_v_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
      raddr_q      <= raddr_d;
    end
  end

  assign r0.rsp_valid  = rsp_v_q[0];
  assign r1.rsp_valid  = rsp_v_q[1];
  assign r0.rsp_rdata  = rsp0_rdata_q;
  assign r1.rsp_rdata  = rsp1_rdata_q;
  assign lock_timeout  = lock_to_q;

endmodule
`default_nettype wire

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Shares the single-read/single-write 8x8 register bank between two requesters (r0, r1) using valid/ready handshakes and round-robin arbitration. Accepts at most one access per cycle, drives the bank ports, and returns registered read data one cycle after acceptance. Supports an atomic lock so one requester can perform read-modify-write sequences without interleaving. A lock timeout prevents starvation.

Parameters:
DATA_W, 8, bank data width
ADDR_W, 3, bank address width (8 registers)
LOCK_TIMEOUT, 16, maximum consecutive cycles a lock may be held before forced release (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
r0_valid  in  1  requester 0 access request
r0_ready  out  1  requester 0 request accepted this cycle
r0_we  in  1  1=write, 0=read
r0_addr  in  ADDR_W  register address
r0_wdata  in  DATA_W  write data
r0_lock  in  1  hold grant after this access (atomic sequence)
r0_rsp_valid  out  1  response pulse, one cycle after acceptance
r0_rsp_rdata  out  DATA_W  read data (0 for write responses)
r1_valid, r1_ready, r1_we, r1_addr, r1_wdata, r1_lock, r1_rsp_valid, r1_rsp_rdata: same as r0
bank_we  out  1  to bank write enable
bank_write_addr  out  ADDR_W  to bank write address
bank_write_data  out  DATA_W  to bank write data
bank_read_addr  out  ADDR_W  to bank read address
bank_read_data  in  DATA_W  combinational read data from bank
lock_timeout  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset (async, rst=1): all ready/rsp_valid/lock_timeout/bank_we = 0; rsp_rdata = 0; bank addresses/data = 0; rr pointer = r0; lock state UNLOCKED; timeout counter = 0.
- Lock FSM states: UNLOCKED, LOCKED_R0, LOCKED_R1.
- UNLOCKED: if only one valid, grant it; if both valid, grant the requester pointed at by rr; rr then points at the other requester. No valid: rr unchanged.
- LOCKED_Rx: only Rx can be granted; the other requester's ready = 0 regardless of valid.
- Grant is combinational in the cycle: rX_ready = 1 for the granted requester only; a transfer occurs when valid && ready.
- Bank drive on transfer: write -> bank_we=1, bank_write_addr/data = request fields, commits at the closing clk edge; read -> bank_read_addr = addr, bank_read_data captured into rX_rsp_rdata at the closing edge. bank_we = 0 when there is no write transfer.
- Response: rX_rsp_valid = 1 in cycle N+1 for one cycle, for both reads and writes. No response backpressure. Write response rdata = 0.
- Read addr when idle: holds last value (no bank side effects).
- Lock entry: a transfer with rX_lock=1 in UNLOCKED -> LOCKED_Rx, counter cleared.
- Lock exit: a transfer by Rx with rX_lock=0 -> UNLOCKED. Deasserting lock without a transfer does not release it.
- Timeout: the counter increments each cycle while locked and clears on lock entry. When the counter reaches LOCK_TIMEOUT-1, the FSM goes to UNLOCKED, lock_timeout pulses, and rr points at the other requester. A transfer occurring in that same cycle still completes normally.
- Same-cycle read-after-write to the same address: the read returns the old value (bank semantics). The next cycle returns the new value.
- Reset mid-operation: pending responses are dropped, the lock is cleared, and bank_we drops immediately.

Decomposition:
- Shared package reg_bank_pkg: DATA_W/ADDR_W constants; lock state enum (UNLOCKED=2'd0, LOCKED_R0=2'd1, LOCKED_R1=2'd2).
- One natural sub-module: rr_arbiter2 (2-way round-robin grant with pointer update enable). Lock FSM, timeout counter and response registers stay in the top module.

Test Plan:
- r0 write addr 3 data 0xA5, then r0 read addr 3 -> bank_we=1 on first cycle; r0_rsp_valid next cycle with rdata=0x00, then rdata=0xA5.
- r0 and r1 both reading continuously after reset -> grants alternate r0,r1,r0,r1; each rsp_valid appears exactly one cycle after its ready.
- r1 read addr 5 with lock=1, then r1 write addr 5 = 0x3C with lock=0, while r0 valid throughout -> r0_ready=0 until r1's unlocking write, then r0 granted next cycle.
- r0 locks then stays idle with r1 valid, LOCK_TIMEOUT=16 -> lock_timeout pulse 16 cycles after lock entry; r1 granted the following cycle.
- Same-cycle: r0 write addr 2=0x11 while r1 pending read addr 2 -> r1 gets the old value if granted the next cycle? No: r1's read in the following cycle returns 0x11.
- Assert rst while locked with a read accepted -> no rsp_valid after reset, state UNLOCKED, rr=r0, all outputs 0.
